// File: rtl/multiplier_pkg.sv
// Types and helpers shared by the Montgomery multiplier datapath blocks.
package multiplier_pkg;

  import params_pkg::*;

  // Counter must hold the full range 0..DATA_LENGTH.
  localparam int unsigned CNT_W = $clog2(DATA_LENGTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} mont_conv_state_e;

  function automatic logic [CNT_W-1:0] clamp_bl(input logic [DATA_LENGTH-1:0] bl);
    if (bl > DATA_LENGTH'(DATA_LENGTH)) begin
      return CNT_W'(DATA_LENGTH);
    end
    return bl[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/params_pkg.sv
// Shared arithmetic parameters: operand width and the default (Dilithium) modulus.
package params_pkg;

  localparam int unsigned DATA_LENGTH    = 32;
  localparam logic [DATA_LENGTH-1:0] MODULUS = DATA_LENGTH'(8380417);
  localparam int unsigned MODULUS_LENGTH = 23;

endpackage

// File: rtl/mod_double_step.sv
// Combinational modular doubling: dbl_o = (2 * acc_i) mod m_i, assuming acc_i < m_i.
module mod_double_step
  import params_pkg::*;
(
  input  logic [DATA_LENGTH-1:0] acc_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  output logic [DATA_LENGTH-1:0] dbl_o
);

  logic [DATA_LENGTH:0] t;
  logic [DATA_LENGTH:0] m_ext;

  // Compare and subtract one bit wider than the operands so the carry-out of the shift counts.
  always_comb begin
    t     = {acc_i, 1'b0};
    m_ext = {1'b0, m_i};
    dbl_o = DATA_LENGTH'((t >= m_ext) ? (t - m_ext) : t);
  end

endmodule

// File: rtl/mont_form_converter.sv
// Serial Montgomery-form converter: y_mont = y * 2^k mod m via k modular doublings.
// Optional input range check enabled by defining MONT_CONV_RANGE_CHECK_EN.
module mont_form_converter
  import params_pkg::*;
  import multiplier_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] y_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  output logic [DATA_LENGTH-1:0] x_o,
  output logic [DATA_LENGTH-1:0] y_mont_o,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic                   error_o
);

  mont_conv_state_e state_q, state_d;

  logic [DATA_LENGTH-1:0] acc_q, acc_d;
  logic [DATA_LENGTH-1:0] x_q, m_q, dbl;
  logic [DATA_LENGTH-1:0] x_out_q, y_mont_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d, k;
  logic                   valid_q, accept, bad_in;

  assign k = clamp_bl(m_bl_i);

`ifdef MONT_CONV_RANGE_CHECK_EN
  logic err_q, error_q;
  assign bad_in  = (y_i >= m_i) || (m_i == '0);
  assign error_o = error_q;
`else
  assign bad_in  = 1'b0;
  assign error_o = 1'b0;
`endif

  mod_double_step u_step (
    .acc_i (acc_q),
    .m_i   (m_q),
    .dbl_o (dbl)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          acc_d   = y_i;
          cnt_d   = k;
          state_d = ((k == '0) || bad_in) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_d = dbl;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      x_q      <= '0;
      m_q      <= '0;
      x_out_q  <= '0;
      y_mont_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_q == DONE);
      if (accept) begin
        x_q <= x_i;
        m_q <= m_i;
      end
      // Result registers update only on leaving DONE, so they hold through IDLE.
      if (state_q == DONE) begin
        x_out_q <= x_q;
`ifdef MONT_CONV_RANGE_CHECK_EN
        y_mont_q <= err_q ? '0 : acc_q;
`else
        y_mont_q <= acc_q;
`endif
      end
    end
  end

`ifdef MONT_CONV_RANGE_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q   <= 1'b0;
      error_q <= 1'b0;
    end else if (accept) begin
      err_q   <= bad_in;
      error_q <= 1'b0;
    end else if (state_q == DONE) begin
      error_q <= err_q;
    end
  end
`endif

  assign x_o      = x_out_q;
  assign y_mont_o = y_mont_q;
  assign valid_o  = valid_q;
  assign busy_o   = (state_q != IDLE);

endmodule
